// File: rtl/conv33_pkg.sv
// Shared definitions for the 3x3 convolution output path: default sizes and
// the output-stage state encoding.
package conv33_pkg;

  localparam int unsigned ACC_W_DEF  = 32;
  localparam int unsigned OUT_W_DEF  = 8;
  localparam int unsigned NUM_CH_DEF = 8;
  localparam int unsigned SHIFT_DEF  = 8;

  localparam int unsigned CH_W = $clog2(NUM_CH_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/conv33_requant.sv
// Combinational requantiser: round-half-up, arithmetic right shift, ReLU and
// unsigned saturation of one signed accumulator to OUT_W bits.
module conv33_requant #(
  parameter int unsigned ACC_W = 32,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned SHIFT = 8
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic        [OUT_W-1:0] q
);

  // One guard bit so the rounding add can never overflow.
  localparam logic signed [ACC_W:0] Half = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);

  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] r;

  always_comb begin
    sum = {acc[ACC_W-1], acc} + Half;
    r   = sum >>> SHIFT;
    if (r[ACC_W]) begin
      q = '0;
    end else if (|r[ACC_W-1:OUT_W]) begin
      q = '1;
    end else begin
      q = r[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/conv33_out_stage.sv
// Output stage: captures NUM_CH accumulators on calc_valid, then streams the
// requantised channels one per valid/ready beat once the controller allows it.
module conv33_out_stage
  import conv33_pkg::*;
#(
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned OUT_W  = OUT_W_DEF,
  parameter int unsigned NUM_CH = NUM_CH_DEF,
  parameter int unsigned SHIFT  = SHIFT_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        calc_valid,
  input  logic [NUM_CH*ACC_W-1:0]     acc_data,
  input  logic                        output_en,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [OUT_W-1:0]            out_data,
  output logic [$clog2(NUM_CH)-1:0]   out_ch,
  output logic                        output_done,
  output logic                        overrun_err
);

  localparam int unsigned ChW = $clog2(NUM_CH);
  localparam logic [ChW-1:0] LastCh = ChW'(NUM_CH - 1);

  state_e                  state_q;
  logic signed [ACC_W-1:0] cap_q [NUM_CH];

  logic [ChW-1:0]          sel_ch;
  logic signed [ACC_W-1:0] sel_acc;
  logic [OUT_W-1:0]        req;

  // The requantiser always looks at the channel that the next register load
  // will present: ch0 when leaving HOLD, out_ch+1 while sending.
  always_comb begin
    sel_ch = '0;
    if (state_q == SEND && out_ch != LastCh) begin
      sel_ch = out_ch + ChW'(1);
    end
    sel_acc = cap_q[sel_ch];
  end

  conv33_requant #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_requant (
    .acc (sel_acc),
    .q   (req)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_ch      <= '0;
      output_done <= 1'b0;
      overrun_err <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        cap_q[k] <= '0;
      end
    end else begin
      output_done <= 1'b0;
      if (calc_valid && state_q != IDLE) begin
        overrun_err <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (calc_valid) begin
            for (int k = 0; k < NUM_CH; k++) begin
              cap_q[k] <= acc_data[k*ACC_W +: ACC_W];
            end
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (output_en) begin
            state_q   <= SEND;
            out_valid <= 1'b1;
            out_ch    <= '0;
            out_data  <= req;
          end
        end
        SEND: begin
          // out_valid is always high here, so out_ready alone is the handshake.
          if (out_ready) begin
            if (out_ch == LastCh) begin
              out_valid   <= 1'b0;
              output_done <= 1'b1;
              state_q     <= DONE;
            end else begin
              out_ch   <= sel_ch;
              out_data <= req;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
